// File: rtl/ram_pkg.sv
// Shared types and default geometry for ram_master and its RAM.
// Holds the FSM state encoding and default MEM_WIDTH/MEM_DEPTH.
package ram_pkg;

  localparam int MEM_WIDTH_DEF = 16;
  localparam int MEM_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_t;

endpackage

// File: rtl/ram_master_if.sv
// CPU-facing request/response bundle for ram_master.
// master: load/store unit side; slave: ram_master side.
interface ram_master_if
  import ram_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
);

  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [MEM_WIDTH-1:0]  req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [MEM_WIDTH-1:0]  rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/ram_master.sv
// Request controller for a dual-port sync RAM: bus (req/rsp), wr_err,
// ram_w_en/addr/data and ram_r_en/addr out, ram_r_data in; clk, rst.
module ram_master
  import ram_pkg::*;
#(
  parameter int  MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int  MEM_DEPTH  = MEM_DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_master_if.slave           bus,
  output logic                  wr_err,
  output logic                  ram_w_en,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [MEM_WIDTH-1:0]  ram_w_data,
  input  logic [MEM_WIDTH-1:0]  ram_r_data
);

  state_t               state;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [MEM_WIDTH-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 pend_err;
  logic                 in_range;
  logic                 accept;
  logic                 wr_acc;
  logic                 rd_acc;

  // Only non-power-of-two depths can actually fail this.
  assign in_range = 32'(bus.req_addr) < 32'(MEM_DEPTH);

  // In RSP a new request rides on the response handshake.
  always_comb begin
    req_ready = 1'b0;
    unique case (state)
      IDLE:    req_ready = !rst;
      RSP:     req_ready = bus.rsp_ready && !rst;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = bus.req_valid && req_ready;
  assign wr_acc = accept && bus.req_we;
  assign rd_acc = accept && !bus.req_we;

  assign ram_w_en   = wr_acc && in_range;
  assign ram_r_en   = rd_acc && in_range;
  assign ram_w_addr = bus.req_addr;
  assign ram_r_addr = bus.req_addr;
  assign ram_w_data = bus.req_wdata;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_err    <= 1'b0;
      pend_err  <= 1'b0;
    end else begin
      wr_err <= wr_acc && !in_range;
      if (rd_acc) pend_err <= !in_range;
      unique case (state)
        IDLE: begin
          if (rd_acc) state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Dropped reads never strobed the RAM, so its data is stale.
          rsp_valid <= 1'b1;
          rsp_rdata <= pend_err ? '0 : ram_r_data;
          rsp_err   <= pend_err;
          state     <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= rd_acc ? RD_WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master with a non-power-of-two depth.
// Random traffic is checked against an array model of the RAM contents.
module tb_ram_master;
  import ram_pkg::*;

  localparam int W  = 16;
  localparam int D  = 200;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_err;
  logic          ram_w_en;
  logic          ram_r_en;
  logic [AW-1:0] ram_w_addr;
  logic [AW-1:0] ram_r_addr;
  logic [W-1:0]  ram_w_data;
  logic [W-1:0]  ram_r_data;

  always #5 clk = ~clk;

  ram_master_if #(.MEM_WIDTH(W), .MEM_DEPTH(D)) bus ();

  ram_master #(.MEM_WIDTH(W), .MEM_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .wr_err     (wr_err),
    .ram_w_en   (ram_w_en),
    .ram_r_en   (ram_r_en),
    .ram_w_addr (ram_w_addr),
    .ram_r_addr (ram_r_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data)
  );

  logic [W-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_w_en) ram[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= ram[ram_r_addr];
  end

  logic [W-1:0] mdl [0:D-1];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] exp_data(input int a);
    return (a < D) ? mdl[a] : '0;
  endfunction

  task automatic idle_in();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
  endtask

  // Present one request until accepted; records what the RAM side saw.
  task automatic send(input logic we, input logic [AW-1:0] a,
                      input logic [W-1:0] d, output int waits,
                      output logic wen, output logic ren,
                      output logic [AW-1:0] wa, output logic [AW-1:0] ra,
                      output logic [W-1:0] wd);
    bit done;
    done = 0;
    waits = 0;
    wen = 0; ren = 0; wa = '0; ra = '0; wd = '0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        done = 1;
        wen = ram_w_en; ren = ram_r_en;
        wa = ram_w_addr; ra = ram_r_addr; wd = ram_w_data;
      end else if (waits >= 20) begin
        done = 1;
        waits = -1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    if (waits >= 0 && we && int'(a) < D) mdl[a] = d;
  endtask

  // Called the cycle after a read accept; lat counts cycles from accept.
  task automatic get_rsp(input int stall, output int lat,
                         output logic [W-1:0] d, output logic e);
    bit got;
    got = 0;
    lat = 0;
    bus.rsp_ready = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid === 1'b1) got = 1;
      else begin @(posedge clk); #1; end
    end
    d = bus.rsp_rdata;
    e = bus.rsp_err;
    if (!got) lat = -1;
    repeat (stall) begin @(posedge clk); #1; end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 1'b0 || ram_w_en !== 1'b0 || ram_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: ready=%b w_en=%b r_en=%b want 0 0 0",
               bus.req_ready, ram_w_en, ram_r_en);
    end
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 ||
        bus.rsp_err !== 1'b0 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: valid=%b rdata=%h err=%b wr_err=%b want 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, wr_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b want 1 0",
               bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int w; int lat;
    logic wen, ren, e;
    logic [AW-1:0] wa, ra;
    logic [W-1:0] wd, d;
    send(1'b1, 8'h10, 16'hBEEF, w, wen, ren, wa, ra, wd);
    n_chk++;
    if (w !== 0 || wen !== 1'b1 || ren !== 1'b0 ||
        wa !== 8'h10 || wd !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wr_basic: waits=%0d w_en=%b r_en=%b addr=%h data=%h want 0 1 0 10 beef",
               w, wen, ren, wa, wd);
    end
    send(1'b0, 8'h10, 16'h0, w, wen, ren, wa, ra, wd);
    n_chk++;
    if (w !== 0 || ren !== 1'b1 || wen !== 1'b0 || ra !== 8'h10) begin
      n_fail++;
      $display("FAIL rd_basic: waits=%0d r_en=%b w_en=%b addr=%h want 0 1 0 10",
               w, ren, wen, ra);
    end
    get_rsp(0, lat, d, e);
    n_chk++;
    if (lat !== 2 || d !== 16'hBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_basic_rsp: lat=%0d data=%h err=%b want 2 beef 0", lat, d, e);
    end
  endtask

  task automatic test_back_to_back();
    int w; int c0; int lat;
    logic wen, ren, e;
    logic [AW-1:0] wa, ra;
    logic [W-1:0] wd, d;
    logic [W-1:0] dat [4];
    dat[0] = 16'h1111; dat[1] = 16'h2222;
    dat[2] = 16'h3333; dat[3] = 16'h4444;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, AW'(i), dat[i], w, wen, ren, wa, ra, wd);
      n_chk++;
      if (w !== 0 || wen !== 1'b1 || wa !== AW'(i) || wd !== dat[i]) begin
        n_fail++;
        $display("FAIL b2b_wr%0d: waits=%0d w_en=%b addr=%h data=%h want 0 1 %h %h",
                 i, w, wen, wa, wd, AW'(i), dat[i]);
      end
    end
    n_chk++;
    if (cyc - c0 !== 4) begin
      n_fail++;
      $display("FAIL b2b_cycles: got %0d want 4", cyc - c0);
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b0, AW'(i), '0, w, wen, ren, wa, ra, wd);
      get_rsp(0, lat, d, e);
      n_chk++;
      if (lat !== 2 || d !== exp_data(i) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_rd%0d: lat=%0d data=%h err=%b want 2 %h 0",
                 i, lat, d, e, exp_data(i));
      end
    end
  endtask

  task automatic test_backpressure();
    int w; int n;
    logic wen, ren;
    logic [AW-1:0] wa, ra;
    logic [W-1:0] wd, dv;
    bit got;
    dv = W'($urandom);
    send(1'b1, 8'd77, dv, w, wen, ren, wa, ra, wd);
    send(1'b0, 8'd77, '0, w, wen, ren, wa, ra, wd);
    bus.rsp_ready = 1'b0;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid === 1'b1) got = 1;
      else begin @(posedge clk); #1; end
    end
    n_chk++;
    if (!got || n !== 2) begin
      n_fail++;
      $display("FAIL bp_arrive: got=%0d lat=%0d want 1 2", got, n);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'd3;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== dv ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0 || ram_r_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h err=%b ready=%b r_en=%b want 1 %h 0 0 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                 bus.req_ready, ram_r_en, dv);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b want 1 1",
               bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: valid=%b ready=%b want 0 1",
               bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bounds();
    int w; int lat; int pulses;
    logic wen, ren, e;
    logic [AW-1:0] wa, ra;
    logic [W-1:0] wd, d;
    send(1'b1, 8'd250, 16'hA5A5, w, wen, ren, wa, ra, wd);
    n_chk++;
    if (w !== 0 || wen !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_wr: waits=%0d w_en=%b want 0 0", w, wen);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wr_err === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL oor_wr_err: pulses=%0d want 1", pulses);
    end
    send(1'b0, 8'd250, '0, w, wen, ren, wa, ra, wd);
    n_chk++;
    if (w !== 0 || ren !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_rd: waits=%0d r_en=%b want 0 0", w, ren);
    end
    get_rsp(0, lat, d, e);
    n_chk++;
    if (lat !== 2 || d !== '0 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_rd_rsp: lat=%0d data=%h err=%b want 2 0000 1", lat, d, e);
    end
    send(1'b0, 8'd199, '0, w, wen, ren, wa, ra, wd);
    get_rsp(0, lat, d, e);
    n_chk++;
    if (ren !== 1'b1 || d !== exp_data(199) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_rd: r_en=%b data=%h err=%b want 1 %h 0",
               ren, d, e, exp_data(199));
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic wen, ren;
    logic [AW-1:0] wa, ra;
    logic [W-1:0] wd;
    send(1'b0, 8'h10, '0, w, wen, ren, wa, ra, wd);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid%0d: valid=%b ready=%b want 0 1",
                 i, bus.rsp_valid, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    send(1'b1, 8'h20, 16'h5A5A, w, wen, ren, wa, ra, wd);
    n_chk++;
    if (w !== 0 || wen !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_wr: waits=%0d w_en=%b want 0 1", w, wen);
    end
  endtask

  task automatic test_hs_new_read();
    int w; int n; int lat;
    logic wen, ren, e;
    logic [AW-1:0] wa, ra;
    logic [W-1:0] wd, d, da, db;
    bit got;
    da = W'($urandom);
    db = W'($urandom);
    send(1'b1, 8'd40, da, w, wen, ren, wa, ra, wd);
    send(1'b1, 8'd41, db, w, wen, ren, wa, ra, wd);
    send(1'b0, 8'd40, '0, w, wen, ren, wa, ra, wd);
    bus.rsp_ready = 1'b0;
    got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid === 1'b1) got = 1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'd41;
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 1'b1 || ram_r_en !== 1'b1 || ram_r_addr !== 8'd41 ||
        bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== da) begin
      n_fail++;
      $display("FAIL hs_rd: ready=%b r_en=%b addr=%h valid=%b data=%h want 1 1 29 1 %h",
               bus.req_ready, ram_r_en, ram_r_addr, bus.rsp_valid,
               bus.rsp_rdata, da);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    get_rsp(0, lat, d, e);
    n_chk++;
    if (lat !== 2 || d !== db || e !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_rd_rsp: lat=%0d data=%h err=%b want 2 %h 0", lat, d, e, db);
    end
  endtask

  task automatic test_random();
    int w; int lat; int a;
    logic we, wen, ren, e;
    logic [AW-1:0] wa, ra;
    logic [W-1:0] wd, d, dv;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(D, 255))
                                       : int'($urandom_range(0, D - 1));
      if (i < 12) we = 1'b1;
      dv = W'($urandom);
      send(we, AW'(a), dv, w, wen, ren, wa, ra, wd);
      if (we) begin
        n_chk++;
        if (w !== 0 || wen !== (a < D) || ren !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_wr%0d: a=%0d waits=%0d w_en=%b r_en=%b",
                   i, a, w, wen, ren);
        end
        @(negedge clk);
        n_chk++;
        if (wr_err !== (a >= D)) begin
          n_fail++;
          $display("FAIL rnd_wr_err%0d: a=%0d got %b want %b",
                   i, a, wr_err, (a >= D));
        end
        @(posedge clk); #1;
      end else begin
        n_chk++;
        if (w !== 0 || ren !== (a < D) || wen !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_rd%0d: a=%0d waits=%0d r_en=%b w_en=%b",
                   i, a, w, ren, wen);
        end
        get_rsp($urandom_range(0, 3), lat, d, e);
        n_chk++;
        if (lat !== 2 || d !== exp_data(a) || e !== (a >= D)) begin
          n_fail++;
          $display("FAIL rnd_rsp%0d: a=%0d lat=%0d data=%h err=%b want 2 %h %b",
                   i, a, lat, d, e, exp_data(a), (a >= D));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    ram_r_data = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_bounds();
    test_reset_mid();
    test_hs_new_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_master.md
# ram_master

Request-side controller for the team's simple dual-port synchronous RAM: it turns a CPU-facing valid/ready request stream into the RAM's `w_en`/`r_en` port strobes and returns read data through a buffered valid/ready response channel. It sits between the FPG8 core's load/store unit and one RAM instance. It absorbs the RAM's one-cycle read latency, enforces address bounds for non-power-of-two depths, and applies response backpressure.

## Interface
- `MEM_WIDTH`, 16: data word width; must match the attached RAM.
- `MEM_DEPTH`, 256: number of RAM words; must match the attached RAM.
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`: derived localparam, not overridable.

- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  MEM_WIDTH  write data.
- `rsp_valid`  out  1  read response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  MEM_WIDTH  read data.
- `rsp_err`  out  1  response is for an out-of-range read.
- `wr_err`  out  1  one-cycle pulse: an out-of-range write was dropped.
- `ram_w_en`, `ram_r_en`  out  1  RAM strobes.
- `ram_w_addr`, `ram_r_addr`  out  ADDR_WIDTH  RAM addresses.
- `ram_w_data`  out  MEM_WIDTH  RAM write data.
- `ram_r_data`  in  MEM_WIDTH  RAM read data; valid the cycle after `ram_r_en`.

## Operation
- FSM states: IDLE, RD_WAIT, RSP.
- **IDLE.** `req_ready`=1.
  - Accepted write: `ram_w_en`=1 combinationally in the same cycle, with `ram_w_addr`=`req_addr` and `ram_w_data`=`req_wdata`. The FSM stays in IDLE.
  - Accepted read: `ram_r_en`=1 and `ram_r_addr`=`req_addr` in the same cycle, then go to RD_WAIT.
- **RD_WAIT.** `req_ready`=0. Capture `ram_r_data` into the `rsp_rdata` register, set `rsp_valid`, then go to RSP.
- **RSP.** `rsp_valid`=1 and `rsp_rdata`/`rsp_err` are held stable until the handshake.
  - `req_ready` = `rsp_ready`. A new request may be accepted in the same cycle the response is consumed.
  - Handshake with no new read: clear `rsp_valid` and go to IDLE. A write accepted in that cycle is issued normally.
  - Handshake with a new read: issue the read and go to RD_WAIT.
- **Bounds.** An address is out of range when `req_addr` >= `MEM_DEPTH` (unsigned compare). This is only possible when `MEM_DEPTH` is not a power of two.
  - Out-of-range write: no `ram_w_en`; `wr_err` pulses for 1 cycle.
  - Out-of-range read: no `ram_r_en`, but the FSM still passes through RD_WAIT. The response is `rsp_rdata`=0 with `rsp_err`=1.
- `ram_*_addr`/`ram_w_data` are don't-care while their strobe is low; drive them from `req_*` regardless.
- Requests are serialized, so a RAM read and write never collide in the same cycle. A read issued the cycle after a write to the same address returns the new data.

## Timing
- During and after reset: state IDLE; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `wr_err`=0; `req_ready`=0, `ram_w_en`=0, `ram_r_en`=0 while `rst` is high.
- Write latency: 0 cycles to the RAM strobe. Throughput is 1 write/cycle from IDLE.
- Read latency: the request is accepted at cycle N, `rsp_valid` rises at N+2 (registered), and a back-to-back read can be accepted at N+2 if `rsp_ready` is high. Peak read rate is 1 per 2 cycles.
- `rsp_valid` never drops without a handshake.
- Reset asserted in RD_WAIT or RSP discards the pending response; no `rsp_valid` follows reset release.

## Structure
- Shared package `ram_pkg` holds:
  - the FSM state encoding (2-bit: IDLE=0, RD_WAIT=1, RSP=2);
  - the default `MEM_WIDTH`/`MEM_DEPTH` constants shared with the RAM instance.
- No sub-modules. The response register, FSM and bounds compare live in one module.
- A top-level wrapper instantiates `ram_master` plus the RAM, with `ram_r_data` wired back.

## Test plan
- Reset, then write 0xBEEF to address 0x10 and read address 0x10 → `ram_w_en` pulses in the accept cycle; `rsp_valid` appears 2 cycles after the read accept with `rsp_rdata`=0xBEEF and `rsp_err`=0.
- Four back-to-back writes (addresses 0–3, data 0x1111…0x4444) → `req_ready` stays high and the writes complete in 4 cycles; reads of 0–3 return the matching data.
- Read with `rsp_ready` held low for 5 cycles → `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0 throughout; the response is released on the first cycle `rsp_ready` is high.
- `MEM_DEPTH`=200, write to 250 then read 250 → `wr_err` pulses once with no `ram_w_en`; the read responds `rsp_rdata`=0 with `rsp_err`=1 and no `ram_r_en`.
- Read accepted, then `rst` asserted in RD_WAIT → after release `rsp_valid`=0, the state is IDLE, and the next write is accepted at once.
- Response handshake coincident with a new read → the new read is accepted in that cycle, and its `rsp_valid` follows 2 cycles later with the correct data.
